// File: rtl/ps2_key_decoder_if.sv
// Bundles the raw-byte side (ps2_if FIFO) and the decoded key-event side of the decoder.
// The decoder connects through the master modport and the surrounding logic through the slave modport.
interface ps2_key_decoder_if;
   logic       fifo_empty;
   logic [7:0] fifo_data;
   logic       fifo_rd;
   logic       evt_valid;
   logic       evt_ready;
   logic [7:0] evt_code;
   logic       evt_ext;
   logic       evt_brk;
   logic       evt_hit;
   logic [3:0] evt_idx;

   modport master (
      input  fifo_empty, fifo_data, evt_ready,
      output fifo_rd, evt_valid, evt_code, evt_ext, evt_brk, evt_hit, evt_idx
   );

   modport slave (
      output fifo_empty, fifo_data, evt_ready,
      input  fifo_rd, evt_valid, evt_code, evt_ext, evt_brk, evt_hit, evt_idx
   );
endinterface

// File: rtl/ps2_key_decoder.sv
// PS/2 set-2 scan-code decoder: turns raw bytes into {code, ext, brk} events.
// It also tracks the held state of a configured set of keys.
module ps2_key_decoder #(
   parameter int                    NUM_KEYS        = 8,
   parameter logic [NUM_KEYS*9-1:0] KEY_CODES       = {9'h076, 9'h05A, 9'h174, 9'h16B,
                                                       9'h175, 9'h023, 9'h01B, 9'h01C},
   parameter int                    EVT_DEPTH       = 4,
   parameter bit                    SUPPRESS_REPEAT = 1'b1
) (
   input  logic                i_clk,
   input  logic                i_rst,
   input  logic                i_flush,
   ps2_key_decoder_if.master   bus,
   output logic [NUM_KEYS-1:0] o_key_held
);

   localparam int              PW      = (EVT_DEPTH > 1) ? $clog2(EVT_DEPTH) : 1;
   localparam int              CW      = PW + 1;
   localparam logic [CW-1:0]   DEPTH_C = CW'(EVT_DEPTH);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_EXT   = 2'd1,
      S_BRK   = 2'd2,
      S_PAUSE = 2'd3
   } state_t;

   state_t              r_state;
   state_t              w_state_nxt;
   logic                r_rd;
   logic                r_byte_vld;
   logic [7:0]          r_byte;
   logic [2:0]          r_cnt;
   logic [2:0]          w_cnt_nxt;
   logic                r_brk_ext;
   logic                w_brk_ext_nxt;
   logic [NUM_KEYS-1:0] r_key_held;
   logic [NUM_KEYS-1:0] w_held_nxt;

   logic                w_emit;
   logic                w_track;
   logic [7:0]          w_ev_code;
   logic                w_ev_ext;
   logic                w_ev_brk;
   logic                w_hit;
   logic [3:0]          w_idx;
   logic                w_held_hit;
   logic                w_push;
   logic                w_pop;
   logic                w_rd_nxt;
   logic [14:0]         w_ev_word;
   logic [14:0]         w_head;

   logic [14:0]         r_mem [EVT_DEPTH];
   logic [PW-1:0]       r_wptr;
   logic [PW-1:0]       r_rptr;
   logic [CW-1:0]       r_count;
   logic [CW-1:0]       w_count_nxt;
   logic                r_evt_valid;

   // Acknowledge, self-test and error bytes that never carry a key action
   function automatic logic is_ctrl_byte(input logic [7:0] b);
      case (b)
         8'hFA, 8'hAA, 8'hEE, 8'hFE, 8'h00, 8'hFF: is_ctrl_byte = 1'b1;
         default:                                  is_ctrl_byte = 1'b0;
      endcase
   endfunction

   // Prefix-sequence FSM: one step per decoded byte, produces the candidate event
   always_comb begin
      w_state_nxt   = r_state;
      w_cnt_nxt     = r_cnt;
      w_brk_ext_nxt = r_brk_ext;
      w_emit        = 1'b0;
      w_track       = 1'b0;
      w_ev_code     = r_byte;
      w_ev_ext      = 1'b0;
      w_ev_brk      = 1'b0;
      if (r_byte_vld) begin
         case (r_state)
            S_IDLE: begin
               if (r_byte == 8'hE0) begin
                  w_state_nxt = S_EXT;
               end else if (r_byte == 8'hF0) begin
                  w_state_nxt   = S_BRK;
                  w_brk_ext_nxt = 1'b0;
               end else if (r_byte == 8'hE1) begin
                  w_state_nxt = S_PAUSE;
                  w_cnt_nxt   = 3'd7;
               end else if (is_ctrl_byte(r_byte)) begin
                  w_state_nxt = S_IDLE;
               end else begin
                  w_emit  = 1'b1;
                  w_track = 1'b1;
               end
            end
            S_EXT: begin
               if (r_byte == 8'hF0) begin
                  w_state_nxt   = S_BRK;
                  w_brk_ext_nxt = 1'b1;
               end else if ((r_byte == 8'h12) || (r_byte == 8'h59)) begin
                  w_state_nxt = S_IDLE;
               end else begin
                  w_state_nxt = S_IDLE;
                  w_emit      = 1'b1;
                  w_track     = 1'b1;
                  w_ev_ext    = 1'b1;
               end
            end
            S_BRK: begin
               w_state_nxt = S_IDLE;
               w_emit      = 1'b1;
               w_track     = 1'b1;
               w_ev_ext    = r_brk_ext;
               w_ev_brk    = 1'b1;
            end
            S_PAUSE: begin
               w_cnt_nxt = r_cnt - 3'd1;
               if (r_cnt == 3'd1) begin
                  w_state_nxt = S_IDLE;
                  w_emit      = 1'b1;
                  w_ev_code   = 8'hE1;
                  w_ev_ext    = 1'b1;
               end else begin
                  w_state_nxt = S_PAUSE;
               end
            end
            default: begin
               w_state_nxt = S_IDLE;
            end
         endcase
      end else begin
         w_state_nxt = r_state;
      end
   end

   // Lowest-index match of {ext, code} against the key table
   always_comb begin
      w_hit      = 1'b0;
      w_idx      = 4'd0;
      w_held_hit = 1'b0;
      for (int i = 0; i < NUM_KEYS; i++) begin
         if (!w_hit && (KEY_CODES[9*i +: 9] == {w_ev_ext, w_ev_code})) begin
            w_hit      = 1'b1;
            w_idx      = 4'(i);
            w_held_hit = r_key_held[i];
         end else begin
            w_hit = w_hit;
         end
      end
   end

   // Held-state update happens even when the event itself is suppressed
   always_comb begin
      w_held_nxt = r_key_held;
      for (int i = 0; i < NUM_KEYS; i++) begin
         if (w_emit && w_track && w_hit && (w_idx == 4'(i))) begin
            w_held_nxt[i] = ~w_ev_brk;
         end else begin
            w_held_nxt[i] = r_key_held[i];
         end
      end
   end

   // Event FIFO bookkeeping and next-read decision; the read slot is reserved in advance
   always_comb begin
      w_push      = w_emit & ~(SUPPRESS_REPEAT & w_track & ~w_ev_brk & w_hit & w_held_hit);
      w_pop       = r_evt_valid & bus.evt_ready;
      w_count_nxt = r_count + CW'(w_push) - CW'(w_pop);
      w_rd_nxt    = ~bus.fifo_empty & ~r_rd & (w_count_nxt < DEPTH_C);
      w_ev_word   = {w_idx, w_hit, w_ev_brk, w_ev_ext, w_ev_code};
   end

   // State, byte capture, held keys and FIFO pointers
   always_ff @(posedge i_clk or negedge i_rst) begin
      if (!i_rst) begin
         r_state     <= S_IDLE;
         r_rd        <= 1'b0;
         r_byte_vld  <= 1'b0;
         r_byte      <= 8'h00;
         r_cnt       <= 3'd0;
         r_brk_ext   <= 1'b0;
         r_key_held  <= '0;
         r_wptr      <= '0;
         r_rptr      <= '0;
         r_count     <= '0;
         r_evt_valid <= 1'b0;
      end else if (i_flush) begin
         r_state     <= S_IDLE;
         r_rd        <= 1'b0;
         r_byte_vld  <= 1'b0;
         r_byte      <= 8'h00;
         r_cnt       <= 3'd0;
         r_brk_ext   <= 1'b0;
         r_key_held  <= '0;
         r_wptr      <= '0;
         r_rptr      <= '0;
         r_count     <= '0;
         r_evt_valid <= 1'b0;
      end else begin
         r_state     <= w_state_nxt;
         r_rd        <= w_rd_nxt;
         r_byte_vld  <= r_rd;
         r_byte      <= r_rd ? bus.fifo_data : r_byte;
         r_cnt       <= w_cnt_nxt;
         r_brk_ext   <= w_brk_ext_nxt;
         r_key_held  <= w_held_nxt;
         r_wptr      <= w_push ? (r_wptr + PW'(1)) : r_wptr;
         r_rptr      <= w_pop ? (r_rptr + PW'(1)) : r_rptr;
         r_count     <= w_count_nxt;
         r_evt_valid <= (w_count_nxt != '0);
      end
   end

   // Event storage
   always_ff @(posedge i_clk) begin
      if (w_push && !i_flush) begin
         r_mem[r_wptr] <= w_ev_word;
      end
   end

   // Head is masked so that every event output reads 0 whenever the FIFO is empty
   always_comb begin
      w_head = r_evt_valid ? r_mem[r_rptr] : 15'd0;
   end

   assign bus.fifo_rd   = r_rd;
   assign bus.evt_valid = r_evt_valid;
   assign bus.evt_code  = w_head[7:0];
   assign bus.evt_ext   = w_head[8];
   assign bus.evt_brk   = w_head[9];
   assign bus.evt_hit   = w_head[10];
   assign bus.evt_idx   = w_head[14:11];
   assign o_key_held    = r_key_held;

endmodule
